// File: rtl/spart_rx_ctrl.sv
// spart_rx_ctrl: host-link receive stage.
// Deserialises an 8N1 UART stream, parses data packets (header + 4 payload
// bytes, little-endian) and single-byte stop commands, and presents sticky
// flags plus the last accepted payload word to the CPU peripheral interface.
module spart_rx_ctrl #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] DATA_HDR     = 8'hA5,
  parameter logic [7:0] STOP_CMD     = 8'h5A,
  parameter int         TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        received_ak,
  input  logic        stop_ak,
  output logic        received_data,
  output logic        stop_data,
  output logic [31:0] rx_word,
  output logic        overrun_err,
  output logic        frame_err
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_B0, P_B1, P_B2, P_B3} p_state_t;

  rx_state_t     rx_state;
  p_state_t      p_state;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          byte_valid;
  logic [23:0]   payload;
  logic [TW-1:0] tmo_cnt;
  logic          rak_prev;
  logic          sak_prev;

  logic rak_rise;
  logic sak_rise;
  logic pkt_done;
  logic commit;
  logic stop_hit;

  assign rak_rise = received_ak & ~rak_prev;
  assign sak_rise = stop_ak & ~sak_prev;
  assign pkt_done = byte_valid & (p_state == P_B3);
  // Commit is allowed when the previous word was consumed, including an ack arriving this very cycle.
  assign commit   = pkt_done & (~received_data | rak_rise);
  assign stop_hit = byte_valid & (p_state == P_IDLE) & (shift == STOP_CMD);

  // Two-stage synchroniser for the asynchronous line, idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // UART bit-level FSM: start qualification, LSB-first sampling, stop check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            bit_cnt <= 3'd0;
            rx_state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt    <= '0;
            rx_state   <= RX_IDLE;
            byte_valid <= rxs;
            frame_err  <= ~rxs;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Packet FSM with inter-byte timeout; payload lanes are collected little-endian.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state <= P_IDLE;
      payload <= 24'h000000;
      tmo_cnt <= '0;
    end else begin
      case (p_state)
        P_IDLE: begin
          tmo_cnt <= '0;
          if (byte_valid && (shift == DATA_HDR)) begin
            p_state <= P_B0;
          end
        end
        P_B0, P_B1, P_B2, P_B3: begin
          if (frame_err || (!byte_valid && (tmo_cnt == TO_M1))) begin
            p_state <= P_IDLE;
            tmo_cnt <= '0;
          end else if (byte_valid) begin
            tmo_cnt <= '0;
            case (p_state)
              P_B0: begin payload[7:0]   <= shift; p_state <= P_B1; end
              P_B1: begin payload[15:8]  <= shift; p_state <= P_B2; end
              P_B2: begin payload[23:16] <= shift; p_state <= P_B3; end
              default: p_state <= P_IDLE;
            endcase
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: p_state <= P_IDLE;
      endcase
    end
  end

  // Sticky flags, ack edge detection and payload commit; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rak_prev      <= 1'b0;
      sak_prev      <= 1'b0;
      received_data <= 1'b0;
      stop_data     <= 1'b0;
      overrun_err   <= 1'b0;
      rx_word       <= 32'h00000000;
    end else begin
      rak_prev      <= received_ak;
      sak_prev      <= stop_ak;
      received_data <= commit ? 1'b1 : (rak_rise ? 1'b0 : received_data);
      stop_data     <= stop_hit ? 1'b1 : (sak_rise ? 1'b0 : stop_data);
      overrun_err   <= overrun_err | (pkt_done & ~commit);
      rx_word       <= commit ? {shift, payload} : rx_word;
    end
  end

endmodule

// File: doc/spart_rx_ctrl.md
Name: spart_rx_ctrl

Overview:
- Host-link receive stage directly upstream of the CPU peripheral interface.
- Deserialises the host PC's 8N1 UART stream and parses command packets.
- Produces the sticky received_data / stop_data flags and the 32-bit payload word that the CPU reads.
- Clears each flag on the matching acknowledge from the peripheral interface.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- DATA_HDR, 8'hA5, header byte that starts a 4-byte data packet.
- STOP_CMD, 8'h5A, single-byte stop-playback command.
- TIMEOUT_BITS, 32, bit periods allowed between packet bytes before the packet is aborted.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rxd  input  1  UART line from host, asynchronous, idle high
- received_ak  input  1  acknowledge for received_data, level from the peripheral interface
- stop_ak  input  1  acknowledge for stop_data, level from the peripheral interface
- received_data  output  1  sticky flag: new payload word available
- stop_data  output  1  sticky flag: host requested playback stop
- rx_word  output  32  last accepted payload word, little-endian
- overrun_err  output  1  sticky: a completed packet was dropped
- frame_err  output  1  one-cycle pulse on bad stop bit

Behaviour:
- Reset: one clock, asynchronous, active-low. Every output is 0, both FSMs are idle, the synchroniser is preset to 1, and all counters are 0. Reset mid-byte or mid-packet discards partial data.
- Synchroniser: rxd passes through a 2-FF synchroniser (rxs). All logic uses rxs only.
- UART FSM states:
  - RX_IDLE: on rxs == 0, go to RX_START and clear the bit counter.
  - RX_START: at count CLKS_PER_BIT/2 - 1, sample rxs. If 1, false start: return to RX_IDLE. If 0, go to RX_DATA and reset the counter.
  - RX_DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After 8 bits, go to RX_STOP.
  - RX_STOP: after CLKS_PER_BIT cycles, sample rxs. If 1, pulse byte_valid (internal) the next cycle with the byte. If 0, pulse frame_err the next cycle and discard the byte. Either way, return to RX_IDLE.
- Packet FSM states:
  - P_IDLE: on byte_valid with DATA_HDR, go to P_B0. With STOP_CMD, set stop_data. Any other byte is ignored.
  - P_B0..P_B3: each byte_valid stores the byte into payload lane n and advances. DATA_HDR and STOP_CMD are treated as plain payload bytes here.
  - Packet completion: on the P_B3 byte, the packet completes and the FSM returns to P_IDLE.
  - Abort: in P_B0..P_B3, a frame_err or TIMEOUT_BITS*CLKS_PER_BIT cycles without byte_valid returns to P_IDLE. Nothing is committed and no flag changes.
- Latency: received_data, stop_data and rx_word update on the clock edge after the byte_valid that completes the packet or command.
- Acknowledge:
  - Each ack is edge-detected (registered previous value). A rising edge clears its flag.
  - A held-high ack does not repeatedly clear.
  - If a set and a clearing rising edge occur in the same cycle, the set wins and the flag stays 1.
- Commit and overrun:
  - On completion, if received_data == 0 or a received_ak rising edge occurs this cycle, rx_word takes the payload and received_data = 1.
  - Otherwise, rx_word is unchanged, the payload is dropped, and overrun_err = 1, held until reset.
- Stop while pending: a stop command while stop_data == 1 leaves it at 1. This is not an error.
- rx_word stability: rx_word is stable except at commit.

Test Plan:
- CLKS_PER_BIT=16: send A5 78 56 34 12 -> rx_word = 32'h12345678 and received_data = 1 one cycle after the last byte_valid. Pulse received_ak high 1 cycle -> received_data = 0 the next cycle, and rx_word is unchanged.
- Send 5A -> stop_data = 1. Hold stop_ak high 10 cycles, then send 5A again while ack is still high -> stop_data clears once, is set again, and stays 1.
- Send A5 5A A5 5A 00 -> rx_word = 32'h005AA55A, stop_data stays 0.
- Glitch rxd low for 4 cycles -> no byte and no frame_err. Send a byte with stop bit = 0 mid-packet -> frame_err pulses 1 cycle, the packet aborts, and flags are unchanged.
- Commit 32'h11111111 without ack, then send packet 32'h22222222 -> overrun_err = 1 and rx_word = 32'h11111111. Raise received_ak, send 32'h33333333 -> rx_word = 32'h33333333, and overrun_err is still 1.
- Send A5 AA, then idle 33 bit periods, then 01 02 03 04 -> no commit. Assert rst_n = 0 mid-byte -> all outputs 0 immediately. After release, a full A5 packet is received correctly.
